rob_alloc_ctrl: RTL and testbench
=================================

Name: rob_alloc_ctrl

Overview:
- Pointer and occupancy controller for the reorder buffer.
- Grants in-order allocation of up to WIDTH ROB slots per cycle to rename and tracks completion and exception bits written back by execution.
- Selects up to WIDTH in-order retirements per cycle for the retire stage.
- Sequences recovery on a retired exception or a branch-mispredict flush.
- Sits between rename, writeback and retire; the ROB payload arrays are indexed by the slot indices this block produces.

Parameters:
- ROB_DEPTH, 64, ROB entries; power of two, ≥ 2*WIDTH.
- WIDTH, 4, allocate and retire lanes per cycle.
- WB_PORTS, 4, writeback completion ports.
- PTR_W, $clog2(ROB_DEPTH), slot index width (derived).

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-low reset.
- alloc_req  in  WIDTH  per-lane allocation request; must be contiguous from lane 0.
- alloc_ok  out  1  all requested lanes accepted this cycle.
- alloc_idx  out  WIDTH*PTR_W  lane i slot = (tail+i) mod ROB_DEPTH.
- wb_valid  in  WB_PORTS  completion strobe per port.
- wb_idx  in  WB_PORTS*PTR_W  completed slot.
- wb_excp  in  WB_PORTS  completed instruction raised an exception.
- retire_stall  in  1  retire stage cannot accept this cycle.
- retire_valid  out  WIDTH  lane i retires slot (head+i).
- retire_idx  out  WIDTH*PTR_W  lane i = (head+i) mod ROB_DEPTH.
- retire_excp  out  1  the highest valid retire lane is an excepting entry.
- flush_valid  in  1  branch mispredict; squash all entries younger than flush_idx.
- flush_idx  in  PTR_W  mispredicted branch slot (kept).
- count  out  PTR_W+1  occupancy.
- full  out  1  count == ROB_DEPTH.
- empty  out  1  count == 0.

Behaviour:
- Reset (asserted low, async): head=0, tail=0, count=0, all complete/excp bits 0, state=RUN.
- Outputs during reset: alloc_ok=0, retire_valid=0, retire_excp=0, empty=1, full=0.
- State: all outputs are combinational from registered state plus same-cycle inputs; state updates on the posedge.
- FSM states are RUN and FLUSH.
  - RUN→FLUSH when a retire lane with excp retires, or when flush_valid=1.
  - FLUSH→RUN unconditionally after one cycle.
  - In FLUSH: alloc_ok=0, retire_valid=0, writebacks are ignored.
- Allocation, with n = popcount(alloc_req):
  - alloc_ok = RUN & !flush_valid & (n ≤ ROB_DEPTH−count); all-or-nothing.
  - n=0 gives alloc_ok=1 with no effect.
  - On grant: tail += n mod ROB_DEPTH; complete and excp bits of the allocated slots are cleared.
  - Free space uses the pre-retire count; same-cycle retirements do not enlarge it.
- Writeback:
  - Sets complete[wb_idx] and, when wb_excp, excp[wb_idx] on the next edge.
  - Multiple ports may hit distinct slots.
  - Writeback to a non-occupied slot is illegal and unchecked; allocation-clear wins if both hit the same slot.
- Retire:
  - Lane i is valid iff RUN & !retire_stall & i<count & complete[head+i] & all lanes j<i valid & no lane j<i has excp.
  - An excepting entry retires in its lane with retire_excp=1; no higher lane is valid that cycle.
  - head += retired count; count = count + n_alloc − n_retire.
- Exception recovery: on an excepting retire, the next state sets tail = new head, count=0, all bits cleared, and the FSM goes to FLUSH.
- Branch flush:
  - younger = (tail − flush_idx − 1) mod ROB_DEPTH.
  - Next state: tail = flush_idx+1, count = count − n_retire − younger, FSM to FLUSH.
  - Same-cycle retires still proceed; same-cycle alloc is refused.
  - If the same cycle also retires an exception, exception recovery wins.
- Wrap-around: all index arithmetic is mod ROB_DEPTH.
- Full/empty: full=(count==ROB_DEPTH), empty=(count==0); head==tail is ambiguous and never used.
- Reset mid-operation discards all state immediately.

Test Plan:
- Reset then 16 cycles of alloc_req=4'b1111 → alloc_ok=1 for cycles 0–15, alloc_idx lane0 = 0,4,…,60; then full=1, count=64, alloc_ok=0 with tail=0.
- Fill 64; writeback slots 0,1,3 → retire_valid=4'b0011, retire_idx 0,1; count=62; after slot 2 completes, slots 2,3 retire next cycle.
- Wrap: head=62, tail=2, slots 62,63,0,1 complete → retire_idx 62,63,0,1, retire_valid=4'b1111, empty=1.
- Exception: slots 0–7 allocated; slot 2 completes with excp; slots 0–3 complete → retire lanes 0–2 valid, retire_excp=1; next cycle FLUSH with count=0, tail=3; the cycle after, RUN with alloc_ok=1.
- Branch flush: head=0, tail=20, flush_idx=9, slots 0,1 retiring same cycle → count=8, tail=10, one FLUSH cycle with alloc_ok=0.
- Async reset pulsed low mid-cycle with count=30 → outputs are reset values immediately, without waiting for a clock edge.
- alloc_req=4'b0111 with 2 free → alloc_ok=0, tail unchanged.

Source files
------------

// File: rtl/rob_alloc_ctrl_if.sv
//------------------------------------------------------------------------------
// Module   : rob_alloc_ctrl_if
// Purpose  : Bundles the rename / writeback / retire / flush signals of the
//            reorder-buffer allocation controller into one interface.
// Ports    : none (signal bundle). Modports:
//              master - pipeline side: drives requests, writebacks, stall,
//                       flush; observes grants, retire lanes and occupancy.
//              slave  - controller side (rob_alloc_ctrl).
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

interface rob_alloc_ctrl_if #(
  parameter int ROB_DEPTH = 64,
  parameter int WIDTH     = 4,
  parameter int WB_PORTS  = 4,
  parameter int PTR_W     = $clog2(ROB_DEPTH)
);
  // Rename side
  logic [WIDTH-1:0]          alloc_req;
  logic                      alloc_ok;
  logic [WIDTH*PTR_W-1:0]    alloc_idx;
  // Writeback side
  logic [WB_PORTS-1:0]       wb_valid;
  logic [WB_PORTS*PTR_W-1:0] wb_idx;
  logic [WB_PORTS-1:0]       wb_excp;
  // Retire side
  logic                      retire_stall;
  logic [WIDTH-1:0]          retire_valid;
  logic [WIDTH*PTR_W-1:0]    retire_idx;
  logic                      retire_excp;
  // Branch recovery
  logic                      flush_valid;
  logic [PTR_W-1:0]          flush_idx;
  // Occupancy
  logic [PTR_W:0]            count;
  logic                      full;
  logic                      empty;

  modport master (
    output alloc_req, wb_valid, wb_idx, wb_excp, retire_stall, flush_valid, flush_idx,
    input  alloc_ok, alloc_idx, retire_valid, retire_idx, retire_excp, count, full, empty
  );

  modport slave (
    input  alloc_req, wb_valid, wb_idx, wb_excp, retire_stall, flush_valid, flush_idx,
    output alloc_ok, alloc_idx, retire_valid, retire_idx, retire_excp, count, full, empty
  );
endinterface

`default_nettype wire

// File: rtl/rob_alloc_ctrl.sv
//------------------------------------------------------------------------------
// Module   : rob_alloc_ctrl
// Purpose  : Head/tail/occupancy controller for the reorder buffer. Grants
//            all-or-nothing in-order allocation of up to WIDTH slots per
//            cycle, records completion/exception bits from writeback, picks
//            up to WIDTH in-order retirements per cycle and sequences
//            recovery (retired exception or branch-mispredict flush).
// Ports    : clk   - clock
//            reset - asynchronous reset, active low
//            bus   - rob_alloc_ctrl_if.slave:
//                      alloc_req/alloc_ok/alloc_idx       rename allocation
//                      wb_valid/wb_idx/wb_excp            completion writeback
//                      retire_stall/retire_valid/_idx/_excp  retirement
//                      flush_valid/flush_idx              mispredict squash
//                      count/full/empty                   occupancy
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module rob_alloc_ctrl #(
  parameter int ROB_DEPTH = 64,
  parameter int WIDTH     = 4,
  parameter int WB_PORTS  = 4,
  parameter int PTR_W     = $clog2(ROB_DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  rob_alloc_ctrl_if.slave  bus
);

  localparam logic [PTR_W:0] c_DEPTH = (PTR_W+1)'(ROB_DEPTH);

  typedef enum logic [0:0] {
    ST_RUN   = 1'b0,
    ST_FLUSH = 1'b1
  } state_t;

  // Registered state
  state_t               r_state;
  logic [PTR_W-1:0]     r_head;
  logic [PTR_W-1:0]     r_tail;
  logic [PTR_W:0]       r_count;
  logic [ROB_DEPTH-1:0] r_complete;
  logic [ROB_DEPTH-1:0] r_excp;

  // Next-state values
  state_t               w_state_nxt;
  logic [PTR_W-1:0]     w_head_nxt;
  logic [PTR_W-1:0]     w_tail_nxt;
  logic [PTR_W:0]       w_count_nxt;
  logic [ROB_DEPTH-1:0] w_complete_nxt;
  logic [ROB_DEPTH-1:0] w_excp_nxt;

  // Combinational helpers
  logic                 w_run;
  logic [PTR_W:0]       w_n_alloc;
  logic [PTR_W:0]       w_free;
  logic                 w_alloc_ok;
  logic [WIDTH-1:0]     w_ret_valid;
  logic [PTR_W:0]       w_n_ret;
  logic                 w_ret_exc;
  logic [PTR_W-1:0]     w_younger;

  assign w_run = (r_state == ST_RUN);

  //--------------------------------------------------------------------------
  // Allocation grant. Free space is measured against the pre-retire count so
  // the grant never depends on this cycle's retirement. The reset term keeps
  // the grant low while reset is held, independent of the register values.
  //--------------------------------------------------------------------------
  always_comb begin : p_alloc
    w_n_alloc = '0;
    for (int i = 0; i < WIDTH; i++) begin
      w_n_alloc = w_n_alloc + (PTR_W+1)'(bus.alloc_req[i]);
    end
    w_free     = c_DEPTH - r_count;
    w_alloc_ok = reset & w_run & ~bus.flush_valid & (w_n_alloc <= w_free);
  end

  //--------------------------------------------------------------------------
  // Retire selection. A lane is valid only if every lower lane retired and
  // none of them was excepting, so the chain stops at the first incomplete
  // entry and directly after an excepting one.
  //--------------------------------------------------------------------------
  always_comb begin : p_retire
    logic                 v_chain;
    logic [PTR_W-1:0]     v_slot;
    v_chain     = reset & w_run & ~bus.retire_stall;
    v_slot      = '0;
    w_ret_valid = '0;
    w_n_ret     = '0;
    w_ret_exc   = 1'b0;
    for (int i = 0; i < WIDTH; i++) begin
      v_slot         = r_head + PTR_W'(i);
      w_ret_valid[i] = v_chain & ((PTR_W+1)'(i) < r_count) & r_complete[v_slot];
      if (w_ret_valid[i]) begin
        w_n_ret = w_n_ret + (PTR_W+1)'(1);
        if (r_excp[v_slot]) begin
          w_ret_exc = 1'b1;
        end
      end
      v_chain = w_ret_valid[i] & ~r_excp[v_slot];
    end
  end

  //--------------------------------------------------------------------------
  // Lane index outputs
  //--------------------------------------------------------------------------
  generate
    for (genvar g = 0; g < WIDTH; g++) begin : g_lane
      assign bus.alloc_idx[g*PTR_W +: PTR_W]  = r_tail + PTR_W'(g);
      assign bus.retire_idx[g*PTR_W +: PTR_W] = r_head + PTR_W'(g);
    end
  endgenerate

  assign bus.alloc_ok     = w_alloc_ok;
  assign bus.retire_valid = w_ret_valid;
  assign bus.retire_excp  = w_ret_exc;
  assign bus.count        = r_count;
  assign bus.full         = (r_count == c_DEPTH);
  assign bus.empty        = (r_count == '0);

  //--------------------------------------------------------------------------
  // Next-state logic. FLUSH is a one-cycle quiet period: nothing allocates,
  // retires or records writebacks. In RUN the precedence is exception
  // recovery, then branch flush, then normal allocate/retire.
  //--------------------------------------------------------------------------
  always_comb begin : p_next
    logic [PTR_W-1:0] v_slot;
    w_state_nxt    = r_state;
    w_head_nxt     = r_head;
    w_tail_nxt     = r_tail;
    w_count_nxt    = r_count;
    w_complete_nxt = r_complete;
    w_excp_nxt     = r_excp;
    v_slot         = '0;
    // Number of entries strictly younger than the mispredicted branch
    w_younger      = r_tail - bus.flush_idx - PTR_W'(1);

    case (r_state)
      ST_FLUSH: begin
        w_state_nxt = ST_RUN;
      end
      default: begin
        w_head_nxt = r_head + w_n_ret[PTR_W-1:0];

        for (int p = 0; p < WB_PORTS; p++) begin
          if (bus.wb_valid[p]) begin
            v_slot                 = bus.wb_idx[p*PTR_W +: PTR_W];
            w_complete_nxt[v_slot] = 1'b1;
            if (bus.wb_excp[p]) begin
              w_excp_nxt[v_slot] = 1'b1;
            end
          end
        end

        // Applied after writeback so a freshly allocated slot starts clean
        if (w_alloc_ok) begin
          for (int i = 0; i < WIDTH; i++) begin
            if (bus.alloc_req[i]) begin
              v_slot                 = r_tail + PTR_W'(i);
              w_complete_nxt[v_slot] = 1'b0;
              w_excp_nxt[v_slot]     = 1'b0;
            end
          end
        end

        if (w_ret_exc) begin
          w_state_nxt    = ST_FLUSH;
          w_tail_nxt     = w_head_nxt;
          w_count_nxt    = '0;
          w_complete_nxt = '0;
          w_excp_nxt     = '0;
        end else if (bus.flush_valid) begin
          // Allocation is refused this cycle, so only retires and the
          // squashed tail region shrink the occupancy.
          w_state_nxt = ST_FLUSH;
          w_tail_nxt  = bus.flush_idx + PTR_W'(1);
          w_count_nxt = r_count - w_n_ret - (PTR_W+1)'(w_younger);
        end else if (w_alloc_ok) begin
          w_tail_nxt  = r_tail + w_n_alloc[PTR_W-1:0];
          w_count_nxt = r_count + w_n_alloc - w_n_ret;
        end else begin
          w_count_nxt = r_count - w_n_ret;
        end
      end
    endcase
  end

  //--------------------------------------------------------------------------
  // State registers
  //--------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state    <= ST_RUN;
      r_head     <= '0;
      r_tail     <= '0;
      r_count    <= '0;
      r_complete <= '0;
      r_excp     <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_head     <= w_head_nxt;
      r_tail     <= w_tail_nxt;
      r_count    <= w_count_nxt;
      r_complete <= w_complete_nxt;
      r_excp     <= w_excp_nxt;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_rob_alloc_ctrl.sv
//------------------------------------------------------------------------------
// Module   : tb_rob_alloc_ctrl
// Purpose  : Self-checking bench for rob_alloc_ctrl. Allocated slots are
//            pushed to an in-order scoreboard when the request is driven;
//            a negedge monitor pops and compares every retiring lane.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module tb_rob_alloc_ctrl;

  localparam int DEPTH = 64;
  localparam int W     = 4;
  localparam int WBP   = 4;
  localparam int PW    = 6;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  rob_alloc_ctrl_if #(.ROB_DEPTH(DEPTH), .WIDTH(W), .WB_PORTS(WBP), .PTR_W(PW)) bus ();

  rob_alloc_ctrl #(.ROB_DEPTH(DEPTH), .WIDTH(W), .WB_PORTS(WBP), .PTR_W(PW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int checks   = 0;
  int failures = 0;
  int sb_q[$];
  int tb_tail  = 0;

  // Retire scoreboard monitor
  always @(negedge clk) begin
    int exp_slot;
    if (reset === 1'b1) begin
      for (int i = 0; i < W; i++) begin
        if (bus.retire_valid[i]) begin
          checks++;
          if (i > 0 && !bus.retire_valid[i-1]) begin
            failures++;
            $display("FAIL sb_retire_gap lane %0d: valid=%b required contiguous", i, bus.retire_valid);
          end else if (sb_q.size() == 0) begin
            failures++;
            $display("FAIL sb_retire lane %0d: got slot %0d, required no retirement", i, bus.retire_idx[i*PW +: PW]);
          end else begin
            exp_slot = sb_q.pop_front();
            if (bus.retire_idx[i*PW +: PW] !== PW'(exp_slot)) begin
              failures++;
              $display("FAIL sb_retire lane %0d: got slot %0d, required %0d", i, bus.retire_idx[i*PW +: PW], exp_slot);
            end
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  //---------------------------------------------------------------- drivers
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.alloc_req    = '0;
    bus.wb_valid     = '0;
    bus.wb_idx       = '0;
    bus.wb_excp      = '0;
    bus.retire_stall = 1'b0;
    bus.flush_valid  = 1'b0;
    bus.flush_idx    = '0;
  endtask

  task automatic wb_set(input int p, input int slot, input bit ex);
    bus.wb_valid[p]          = 1'b1;
    bus.wb_idx[p*PW +: PW]   = PW'(slot);
    bus.wb_excp[p]           = ex;
  endtask

  task automatic push_alloc(input int n);
    for (int i = 0; i < n; i++) sb_q.push_back((tb_tail + i) % DEPTH);
    tb_tail = (tb_tail + n) % DEPTH;
  endtask

  task automatic fill(input int cycles);
    for (int c = 0; c < cycles; c++) begin
      bus.alloc_req = 4'hF;
      push_alloc(4);
      cyc();
    end
    bus.alloc_req = '0;
  endtask

  task automatic do_reset();
    idle_inputs();
    reset = 1'b0;
    sb_q.delete();
    tb_tail = 0;
    @(negedge clk);
    #2 reset = 1'b1;
    cyc();
  endtask

  //---------------------------------------------------------------- tests
  task automatic test_reset();
    idle_inputs();
    reset = 1'b1;
    #2 reset = 1'b0;
    bus.alloc_req = 4'hF;
    @(negedge clk);
    checks++; if (bus.alloc_ok !== 1'b0)     begin failures++; $display("FAIL reset_alloc_ok: got %b required 0", bus.alloc_ok); end
    checks++; if (bus.retire_valid !== 4'h0) begin failures++; $display("FAIL reset_retire_valid: got %b required 0000", bus.retire_valid); end
    checks++; if (bus.retire_excp !== 1'b0)  begin failures++; $display("FAIL reset_retire_excp: got %b required 0", bus.retire_excp); end
    checks++; if (bus.empty !== 1'b1 || bus.full !== 1'b0 || bus.count !== 7'd0) begin
      failures++; $display("FAIL reset_occupancy: empty=%b full=%b count=%0d required 1/0/0", bus.empty, bus.full, bus.count);
    end
    #2 reset = 1'b1;
    bus.alloc_req = '0;
    cyc();
    @(negedge clk);
    checks++; if (bus.alloc_ok !== 1'b1) begin failures++; $display("FAIL zero_req_alloc_ok: got %b required 1", bus.alloc_ok); end
    cyc();
  endtask

  task automatic test_fill();
    do_reset();
    for (int c = 0; c < 16; c++) begin
      bus.alloc_req = 4'hF;
      push_alloc(4);
      @(negedge clk);
      checks++; if (bus.alloc_ok !== 1'b1 || bus.alloc_idx[PW-1:0] !== PW'(4*c)) begin
        failures++; $display("FAIL fill_grant c=%0d: ok=%b idx=%0d required 1/%0d", c, bus.alloc_ok, bus.alloc_idx[PW-1:0], 4*c);
      end
      cyc();
    end
    @(negedge clk);
    checks++; if (bus.full !== 1'b1 || bus.count !== 7'd64) begin
      failures++; $display("FAIL fill_full: full=%b count=%0d required 1/64", bus.full, bus.count);
    end
    checks++; if (bus.alloc_ok !== 1'b0 || bus.alloc_idx[PW-1:0] !== PW'(0)) begin
      failures++; $display("FAIL fill_refuse: ok=%b tail=%0d required 0/0", bus.alloc_ok, bus.alloc_idx[PW-1:0]);
    end
    cyc();
    idle_inputs();
  endtask

  task automatic test_partial_retire();
    wb_set(0, 0, 1'b0); wb_set(1, 1, 1'b0); wb_set(2, 3, 1'b0);
    @(negedge clk);
    checks++; if (bus.retire_valid !== 4'b0000) begin failures++; $display("FAIL wb_latency: got %b required 0000", bus.retire_valid); end
    cyc();
    idle_inputs();
    @(negedge clk);
    checks++; if (bus.retire_valid !== 4'b0011 || bus.retire_idx[2*PW-1:PW] !== PW'(1)) begin
      failures++; $display("FAIL partial_retire: valid=%b lane1=%0d required 0011/1", bus.retire_valid, bus.retire_idx[2*PW-1:PW]);
    end
    cyc();
    @(negedge clk);
    checks++; if (bus.count !== 7'd62 || bus.retire_valid !== 4'b0000) begin
      failures++; $display("FAIL partial_count: count=%0d valid=%b required 62/0000", bus.count, bus.retire_valid);
    end
    wb_set(0, 2, 1'b0);
    cyc();
    idle_inputs();
    bus.retire_stall = 1'b1;
    @(negedge clk);
    checks++; if (bus.retire_valid !== 4'b0000) begin failures++; $display("FAIL stall: got %b required 0000", bus.retire_valid); end
    cyc();
    bus.retire_stall = 1'b0;
    @(negedge clk);
    checks++; if (bus.retire_valid !== 4'b0011 || bus.retire_idx[PW-1:0] !== PW'(2)) begin
      failures++; $display("FAIL gap_fill_retire: valid=%b lane0=%0d required 0011/2", bus.retire_valid, bus.retire_idx[PW-1:0]);
    end
    cyc();
    @(negedge clk);
    checks++; if (bus.count !== 7'd60) begin failures++; $display("FAIL gap_fill_count: got %0d required 60", bus.count); end
    cyc();
  endtask

  task automatic test_wrap();
    int k;
    do_reset();
    fill(16);
    for (int b = 0; b < 62; b += 4) begin
      idle_inputs();
      for (int p = 0; p < 4; p++) if (b + p < 62) wb_set(p, b + p, 1'b0);
      cyc();
    end
    idle_inputs();
    for (k = 0; k < 20 && bus.count !== 7'd2; k++) cyc();
    @(negedge clk);
    checks++; if (bus.count !== 7'd2 || bus.retire_idx[PW-1:0] !== PW'(62)) begin
      failures++; $display("FAIL wrap_drain: count=%0d head=%0d required 2/62", bus.count, bus.retire_idx[PW-1:0]);
    end
    cyc();
    bus.alloc_req = 4'b0011;
    push_alloc(2);
    @(negedge clk);
    checks++; if (bus.alloc_ok !== 1'b1 || bus.alloc_idx[PW-1:0] !== PW'(0) || bus.alloc_idx[2*PW-1:PW] !== PW'(1)) begin
      failures++; $display("FAIL wrap_alloc: ok=%b idx0=%0d idx1=%0d required 1/0/1", bus.alloc_ok, bus.alloc_idx[PW-1:0], bus.alloc_idx[2*PW-1:PW]);
    end
    cyc();
    idle_inputs();
    wb_set(0, 62, 1'b0); wb_set(1, 63, 1'b0); wb_set(2, 0, 1'b0); wb_set(3, 1, 1'b0);
    cyc();
    idle_inputs();
    @(negedge clk);
    checks++; if (bus.retire_valid !== 4'b1111 || bus.retire_idx[3*PW-1:2*PW] !== PW'(0)) begin
      failures++; $display("FAIL wrap_retire: valid=%b lane2=%0d required 1111/0", bus.retire_valid, bus.retire_idx[3*PW-1:2*PW]);
    end
    cyc();
    @(negedge clk);
    checks++; if (bus.empty !== 1'b1 || bus.count !== 7'd0) begin
      failures++; $display("FAIL wrap_empty: empty=%b count=%0d required 1/0", bus.empty, bus.count);
    end
    cyc();
  endtask

  task automatic test_exception();
    do_reset();
    fill(2);
    idle_inputs();
    wb_set(0, 0, 1'b0); wb_set(1, 1, 1'b0); wb_set(2, 2, 1'b1); wb_set(3, 3, 1'b0);
    cyc();
    idle_inputs();
    @(negedge clk);
    checks++; if (bus.retire_valid !== 4'b0111 || bus.retire_excp !== 1'b1) begin
      failures++; $display("FAIL excp_retire: valid=%b excp=%b required 0111/1", bus.retire_valid, bus.retire_excp);
    end
    cyc();
    sb_q.delete();
    tb_tail = 3;
    bus.alloc_req = 4'hF;
    @(negedge clk);
    checks++; if (bus.count !== 7'd0 || bus.alloc_idx[PW-1:0] !== PW'(3) || bus.alloc_ok !== 1'b0) begin
      failures++; $display("FAIL excp_flush: count=%0d tail=%0d ok=%b required 0/3/0", bus.count, bus.alloc_idx[PW-1:0], bus.alloc_ok);
    end
    checks++; if (bus.retire_valid !== 4'b0000) begin failures++; $display("FAIL excp_flush_retire: got %b required 0000", bus.retire_valid); end
    cyc();
    push_alloc(4);
    @(negedge clk);
    checks++; if (bus.alloc_ok !== 1'b1 || bus.alloc_idx[PW-1:0] !== PW'(3)) begin
      failures++; $display("FAIL excp_resume: ok=%b idx=%0d required 1/3", bus.alloc_ok, bus.alloc_idx[PW-1:0]);
    end
    cyc();
    idle_inputs();
    @(negedge clk);
    checks++; if (bus.count !== 7'd4 || bus.retire_valid !== 4'b0000) begin
      failures++; $display("FAIL excp_realloc: count=%0d valid=%b required 4/0000", bus.count, bus.retire_valid);
    end
    cyc();
  endtask

  task automatic test_branch_flush();
    do_reset();
    fill(5);
    idle_inputs();
    wb_set(0, 0, 1'b0); wb_set(1, 1, 1'b0);
    cyc();
    idle_inputs();
    bus.flush_valid = 1'b1;
    bus.flush_idx   = PW'(9);
    bus.alloc_req   = 4'hF;
    @(negedge clk);
    checks++; if (bus.retire_valid !== 4'b0011 || bus.alloc_ok !== 1'b0) begin
      failures++; $display("FAIL flush_same_cycle: valid=%b ok=%b required 0011/0", bus.retire_valid, bus.alloc_ok);
    end
    cyc();
    bus.flush_valid = 1'b0;
    while (sb_q.size() > 0 && sb_q[$] != 9) void'(sb_q.pop_back());
    tb_tail = 10;
    @(negedge clk);
    checks++; if (bus.count !== 7'd8 || bus.alloc_idx[PW-1:0] !== PW'(10) || bus.alloc_ok !== 1'b0) begin
      failures++; $display("FAIL flush_state: count=%0d tail=%0d ok=%b required 8/10/0", bus.count, bus.alloc_idx[PW-1:0], bus.alloc_ok);
    end
    cyc();
    push_alloc(4);
    @(negedge clk);
    checks++; if (bus.alloc_ok !== 1'b1 || bus.alloc_idx[PW-1:0] !== PW'(10)) begin
      failures++; $display("FAIL flush_resume: ok=%b idx=%0d required 1/10", bus.alloc_ok, bus.alloc_idx[PW-1:0]);
    end
    cyc();
    idle_inputs();
    @(negedge clk);
    checks++; if (bus.count !== 7'd12) begin failures++; $display("FAIL flush_realloc_count: got %0d required 12", bus.count); end
    cyc();
  endtask

  task automatic test_async_reset();
    do_reset();
    fill(7);
    bus.alloc_req = 4'b0011;
    push_alloc(2);
    cyc();
    bus.alloc_req = 4'hF;
    checks++; if (bus.count !== 7'd30) begin failures++; $display("FAIL async_pre_count: got %0d required 30", bus.count); end
    #2 reset = 1'b0;
    #1;
    checks++; if (bus.count !== 7'd0 || bus.empty !== 1'b1 || bus.full !== 1'b0) begin
      failures++; $display("FAIL async_reset_occ: count=%0d empty=%b full=%b required 0/1/0", bus.count, bus.empty, bus.full);
    end
    checks++; if (bus.alloc_ok !== 1'b0 || bus.alloc_idx[PW-1:0] !== PW'(0)) begin
      failures++; $display("FAIL async_reset_alloc: ok=%b tail=%0d required 0/0", bus.alloc_ok, bus.alloc_idx[PW-1:0]);
    end
    @(negedge clk);
    #2 reset = 1'b1;
    sb_q.delete();
    tb_tail = 0;
    idle_inputs();
    cyc();
  endtask

  task automatic test_no_room();
    do_reset();
    fill(15);
    bus.alloc_req = 4'b0011;
    push_alloc(2);
    cyc();
    bus.alloc_req = 4'b0111;
    @(negedge clk);
    checks++; if (bus.alloc_ok !== 1'b0 || bus.alloc_idx[PW-1:0] !== PW'(62) || bus.count !== 7'd62) begin
      failures++; $display("FAIL no_room_refuse: ok=%b tail=%0d count=%0d required 0/62/62", bus.alloc_ok, bus.alloc_idx[PW-1:0], bus.count);
    end
    cyc();
    bus.alloc_req = 4'b0011;
    push_alloc(2);
    @(negedge clk);
    checks++; if (bus.alloc_ok !== 1'b1 || bus.alloc_idx[PW-1:0] !== PW'(62)) begin
      failures++; $display("FAIL exact_fit: ok=%b tail=%0d required 1/62", bus.alloc_ok, bus.alloc_idx[PW-1:0]);
    end
    cyc();
    idle_inputs();
    @(negedge clk);
    checks++; if (bus.full !== 1'b1 || bus.count !== 7'd64) begin
      failures++; $display("FAIL exact_fit_full: full=%b count=%0d required 1/64", bus.full, bus.count);
    end
    cyc();
  endtask

  initial begin
    test_reset();
    test_fill();
    test_partial_retire();
    test_wrap();
    test_exception();
    test_branch_flush();
    test_async_reset();
    test_no_room();
    checks++; if (sb_q.size() > 64) begin failures++; $display("FAIL sb_size: got %0d required <= 64", sb_q.size()); end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
